// File: rtl/gt_apb_initiator.sv
// gt_apb_initiator
//
// Requester-side APB4 engine for the transceiver control port of the 25G
// MAC/GT wrapper. It accepts one register read or write at a time on a
// valid/ready request channel and runs the APB SETUP and ACCESS phases.
// The ACCESS phase has an optional bound on how long it waits for pready.
// The result goes back on a valid/ready response channel.
//
// Ports:
//   clk, rst_n           control clock, asynchronous active-low reset
//   s_req_*              request channel (write flag, address, data, strobes)
//   m_rsp_*              response channel (read data, error, timeout flag)
//   m_apb_*              APB4 requester interface toward the responder
//   busy                 high whenever a transaction is in flight
//   err_count            saturating count of errored transactions
//
// Every output is registered. The always_comb block computes the next value
// of each register, and a single always_ff block loads them.

module gt_apb_initiator #(
  parameter int          ADDR_W    = 18,
  parameter int          DATA_W    = 16,
  parameter int          STRB_W    = DATA_W / 8,
  parameter int          TIMEOUT   = 1024,
  parameter logic [2:0]  PPROT     = 3'b000,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_req_valid,
  output logic                 s_req_ready,
  input  logic                 s_req_write,
  input  logic [ADDR_W-1:0]    s_req_addr,
  input  logic [DATA_W-1:0]    s_req_wdata,
  input  logic [STRB_W-1:0]    s_req_strb,
  output logic                 m_rsp_valid,
  input  logic                 m_rsp_ready,
  output logic [DATA_W-1:0]    m_rsp_rdata,
  output logic                 m_rsp_err,
  output logic                 m_rsp_timeout,
  output logic [ADDR_W-1:0]    m_apb_paddr,
  output logic                 m_apb_psel,
  output logic                 m_apb_penable,
  output logic                 m_apb_pwrite,
  output logic [DATA_W-1:0]    m_apb_pwdata,
  output logic [STRB_W-1:0]    m_apb_pstrb,
  output logic [2:0]           m_apb_pprot,
  input  logic                 m_apb_pready,
  input  logic [DATA_W-1:0]    m_apb_prdata,
  input  logic                 m_apb_pslverr,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  // The wait counter has to reach TIMEOUT exactly. When the timeout is
  // disabled, the counter is never compared, so one bit is enough.
  localparam int             CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       wait_cnt, wait_cnt_nxt;
  logic                   s_req_ready_nxt;
  logic                   m_rsp_valid_nxt;
  logic [DATA_W-1:0]      m_rsp_rdata_nxt;
  logic                   m_rsp_err_nxt;
  logic                   m_rsp_timeout_nxt;
  logic [ADDR_W-1:0]      paddr_nxt;
  logic                   psel_nxt;
  logic                   penable_nxt;
  logic                   pwrite_nxt;
  logic [DATA_W-1:0]      pwdata_nxt;
  logic [STRB_W-1:0]      pstrb_nxt;
  logic                   busy_nxt;
  logic [ERR_CNT_W-1:0]   err_count_nxt;
  logic                   err_entry;

  // The protection attribute is fixed for every access.
  assign m_apb_pprot = PPROT;

  // Next-state and next-output logic. Every register holds its value unless
  // the current state says otherwise. err_entry marks a move into RESP with
  // an error, whether from pslverr or from a timeout.
  always_comb begin
    state_nxt         = state;
    wait_cnt_nxt      = wait_cnt;
    m_rsp_valid_nxt   = m_rsp_valid;
    m_rsp_rdata_nxt   = m_rsp_rdata;
    m_rsp_err_nxt     = m_rsp_err;
    m_rsp_timeout_nxt = m_rsp_timeout;
    paddr_nxt         = m_apb_paddr;
    psel_nxt          = m_apb_psel;
    penable_nxt       = m_apb_penable;
    pwrite_nxt        = m_apb_pwrite;
    pwdata_nxt        = m_apb_pwdata;
    pstrb_nxt         = m_apb_pstrb;
    err_entry         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (s_req_valid) begin
          paddr_nxt   = s_req_addr;
          pwrite_nxt  = s_req_write;
          pwdata_nxt  = s_req_wdata;
          pstrb_nxt   = s_req_write ? s_req_strb : '0;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready wins over a timeout that expires in the same cycle.
        if (m_apb_pready) begin
          m_rsp_rdata_nxt   = (m_apb_pwrite || m_apb_pslverr) ? '0 : m_apb_prdata;
          m_rsp_err_nxt     = m_apb_pslverr;
          m_rsp_timeout_nxt = 1'b0;
          psel_nxt          = 1'b0;
          penable_nxt       = 1'b0;
          m_rsp_valid_nxt   = 1'b1;
          err_entry         = m_apb_pslverr;
          state_nxt         = ST_RESP;
        end else if ((TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT)) begin
          m_rsp_rdata_nxt   = '0;
          m_rsp_err_nxt     = 1'b1;
          m_rsp_timeout_nxt = 1'b1;
          psel_nxt          = 1'b0;
          penable_nxt       = 1'b0;
          m_rsp_valid_nxt   = 1'b1;
          err_entry         = 1'b1;
          state_nxt         = ST_RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (m_rsp_ready) begin
          m_rsp_valid_nxt = 1'b0;
          state_nxt       = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // With no request buffering, ready and busy follow the state directly.
    s_req_ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt        = (state_nxt != ST_IDLE);

    err_count_nxt = err_count;
    if (err_entry && (err_count != '1)) begin
      err_count_nxt = err_count + ERR_CNT_W'(1);
    end
  end

  // State and output registers. Reset drops psel/penable and any pending
  // response at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      s_req_ready   <= 1'b1;
      m_rsp_valid   <= 1'b0;
      m_rsp_rdata   <= '0;
      m_rsp_err     <= 1'b0;
      m_rsp_timeout <= 1'b0;
      m_apb_paddr   <= '0;
      m_apb_psel    <= 1'b0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      m_apb_pwdata  <= '0;
      m_apb_pstrb   <= '0;
      busy          <= 1'b0;
      err_count     <= '0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      s_req_ready   <= s_req_ready_nxt;
      m_rsp_valid   <= m_rsp_valid_nxt;
      m_rsp_rdata   <= m_rsp_rdata_nxt;
      m_rsp_err     <= m_rsp_err_nxt;
      m_rsp_timeout <= m_rsp_timeout_nxt;
      m_apb_paddr   <= paddr_nxt;
      m_apb_psel    <= psel_nxt;
      m_apb_penable <= penable_nxt;
      m_apb_pwrite  <= pwrite_nxt;
      m_apb_pwdata  <= pwdata_nxt;
      m_apb_pstrb   <= pstrb_nxt;
      busy          <= busy_nxt;
      err_count     <= err_count_nxt;
    end
  end

endmodule
